// File: rtl/tcm_port_arbiter.sv
// Two-master arbiter in front of a single-ported TCM, with a 1-entry response tracker.
// Define TCM_ARB_FIXED_PRIO_EN for fixed m0 priority; default build is round-robin.
module tcm_port_arbiter #(
    parameter bit RESET_PRIO = 1'b0
) (
    input  logic        aclk,
    input  logic        areset,

    input  logic        m0_request,
    input  logic [31:0] m0_address,
    input  logic        m0_write_enable,
    input  logic [3:0]  m0_write_byte_enable,
    input  logic [31:0] m0_write_data,
    output logic        m0_grant,
    output logic        m0_valid,
    output logic [31:0] m0_read_data,

    input  logic        m1_request,
    input  logic [31:0] m1_address,
    input  logic        m1_write_enable,
    input  logic [3:0]  m1_write_byte_enable,
    input  logic [31:0] m1_write_data,
    output logic        m1_grant,
    output logic        m1_valid,
    output logic [31:0] m1_read_data,

    output logic        ram_request,
    output logic        ram_write_enable,
    output logic [31:0] ram_address,
    output logic [3:0]  ram_write_byte_enable,
    output logic [31:0] ram_write_data,
    input  logic        ram_grant,
    input  logic        ram_valid,
    input  logic [31:0] ram_read_data
);

    typedef enum logic {
        MASTER_0 = 1'b0,
        MASTER_1 = 1'b1
    } master_e;

    master_e winner;
    logic    accepted;
    logic    rsp_live;

    logic    pending_q, pending_d;
    master_e owner_q,   owner_d;

`ifndef TCM_ARB_FIXED_PRIO_EN
    master_e prio_q, prio_d;
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        winner = MASTER_0;
`ifdef TCM_ARB_FIXED_PRIO_EN
        if (m1_request && !m0_request) begin
            winner = MASTER_1;
        end
`else
        if (m0_request && !m1_request) begin
            winner = MASTER_0;
        end else if (m1_request && !m0_request) begin
            winner = MASTER_1;
        end else begin
            winner = prio_q;
        end
`endif
    end

    always_comb begin
        ram_request           = (m0_request || m1_request) && !areset;
        ram_write_enable      = m0_write_enable;
        ram_address           = m0_address;
        ram_write_byte_enable = m0_write_byte_enable;
        ram_write_data        = m0_write_data;
        if (winner == MASTER_1) begin
            ram_write_enable      = m1_write_enable;
            ram_address           = m1_address;
            ram_write_byte_enable = m1_write_byte_enable;
            ram_write_data        = m1_write_data;
        end
    end

    // A request only counts as accepted when the RAM takes it outside reset.
    assign accepted = ram_grant && ram_request;
    assign m0_grant = accepted && (winner == MASTER_0) && m0_request;
    assign m1_grant = accepted && (winner == MASTER_1) && m1_request;

    always_comb begin
        pending_d = accepted;
        owner_d   = winner;
`ifndef TCM_ARB_FIXED_PRIO_EN
        prio_d    = prio_q;
        if (accepted) begin
            prio_d = (winner == MASTER_0) ? MASTER_1 : MASTER_0;
        end
`endif
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            pending_q <= 1'b0;
            owner_q   <= MASTER_0;
`ifndef TCM_ARB_FIXED_PRIO_EN
            prio_q    <= master_e'(RESET_PRIO);
`endif
        end else begin
            pending_q <= pending_d;
            owner_q   <= owner_d;
`ifndef TCM_ARB_FIXED_PRIO_EN
            prio_q    <= prio_d;
`endif
        end
    end

    // Responses with nothing outstanding are dropped; the non-owner always sees zeros.
    assign rsp_live     = pending_q && ram_valid && !areset;
    assign m0_valid     = rsp_live && (owner_q == MASTER_0);
    assign m1_valid     = rsp_live && (owner_q == MASTER_1);
    assign m0_read_data = m0_valid ? ram_read_data : 32'h0;
    assign m1_read_data = m1_valid ? ram_read_data : 32'h0;

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Directed bench for tcm_port_arbiter: grants checked per cycle, responses via a scoreboard queue.
module tb_tcm_port_arbiter;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
    } mreq_t;

    typedef struct {
        bit          owner;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        aclk;
    logic        areset;
    logic        m0_request, m1_request;
    logic [31:0] m0_address, m1_address;
    logic        m0_write_enable, m1_write_enable;
    logic [3:0]  m0_write_byte_enable, m1_write_byte_enable;
    logic [31:0] m0_write_data, m1_write_data;
    logic        m0_grant, m1_grant, m0_valid, m1_valid;
    logic [31:0] m0_read_data, m1_read_data;
    logic        ram_request, ram_write_enable;
    logic [31:0] ram_address, ram_write_data;
    logic [3:0]  ram_write_byte_enable;
    logic        ram_grant, ram_valid;
    logic [31:0] ram_read_data;

    int   n_total  = 0;
    int   n_passed = 0;
    int   cyc      = 0;
    bit   inject   = 1'b0;
    exp_t exp_q[$];

    tcm_port_arbiter #(.RESET_PRIO(1'b0)) dut (
        .aclk                 (aclk),
        .areset               (areset),
        .m0_request           (m0_request),
        .m0_address           (m0_address),
        .m0_write_enable      (m0_write_enable),
        .m0_write_byte_enable (m0_write_byte_enable),
        .m0_write_data        (m0_write_data),
        .m0_grant             (m0_grant),
        .m0_valid             (m0_valid),
        .m0_read_data         (m0_read_data),
        .m1_request           (m1_request),
        .m1_address           (m1_address),
        .m1_write_enable      (m1_write_enable),
        .m1_write_byte_enable (m1_write_byte_enable),
        .m1_write_data        (m1_write_data),
        .m1_grant             (m1_grant),
        .m1_valid             (m1_valid),
        .m1_read_data         (m1_read_data),
        .ram_request          (ram_request),
        .ram_write_enable     (ram_write_enable),
        .ram_address          (ram_address),
        .ram_write_byte_enable(ram_write_byte_enable),
        .ram_write_data       (ram_write_data),
        .ram_grant            (ram_grant),
        .ram_valid            (ram_valid),
        .ram_read_data        (ram_read_data)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    function automatic mreq_t mk(input logic r, input logic [31:0] a, input logic w,
                                 input logic [3:0] b, input logic [31:0] d);
        mreq_t m;
        m.req  = r;
        m.addr = a;
        m.we   = w;
        m.be   = b;
        m.wd   = d;
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end else begin
            n_passed++;
        end
    endtask

    // One clock of stimulus: drive at +1, check same-cycle grants at +4, queue the response.
    task automatic step(input mreq_t s0, input mreq_t s1, input bit rg, input bit rst,
                        input bit inj, input bit eg0, input bit eg1, input bit rsp);
        exp_t e;
        @(posedge aclk);
        #1;
        areset               = rst;
        m0_request           = s0.req;
        m0_address           = s0.addr;
        m0_write_enable      = s0.we;
        m0_write_byte_enable = s0.be;
        m0_write_data        = s0.wd;
        m1_request           = s1.req;
        m1_address           = s1.addr;
        m1_write_enable      = s1.we;
        m1_write_byte_enable = s1.be;
        m1_write_data        = s1.wd;
        ram_grant            = rg;
        inject               = inj;
        #3;
        check("grant{m1,m0}", {30'h0, m1_grant, m0_grant}, {30'h0, eg1, eg0});
        if (rsp && (eg0 || eg1)) begin
            e.owner = eg1;
            e.data  = mem_word(eg1 ? s1.addr : s0.addr);
            e.due   = cyc + 1;
            exp_q.push_back(e);
        end
    endtask

    // RAM model: answers one cycle after an accepted request, or on demand for an injected stray valid.
    initial begin
        bit          acc;
        logic [31:0] addr;
        acc           = 1'b0;
        addr          = 32'h0;
        ram_valid     = 1'b0;
        ram_read_data = 32'h0;
        forever begin
            @(posedge aclk);
            #2;
            if (acc) begin
                ram_valid     = 1'b1;
                ram_read_data = mem_word(addr);
            end else if (inject) begin
                ram_valid     = 1'b1;
                ram_read_data = 32'hFFFF_0000;
            end else begin
                ram_valid     = 1'b0;
                ram_read_data = 32'h0;
            end
            #2;
            acc  = ram_request && ram_grant;
            addr = ram_address;
        end
    end

    // Monitor: compares a response exactly in the cycle it is due, flags any unexpected valid.
    initial begin
        exp_t e;
        forever begin
            @(posedge aclk);
            #3;
            cyc++;
            #1;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                check("rsp_valid{m1,m0}", {30'h0, m1_valid, m0_valid},
                      e.owner ? 32'h2 : 32'h1);
                check("rsp_owner_data", e.owner ? m1_read_data : m0_read_data, e.data);
                check("rsp_other_data", e.owner ? m0_read_data : m1_read_data, 32'h0);
            end else if (m0_valid || m1_valid) begin
                check("unexpected_valid{m1,m0}", {30'h0, m1_valid, m0_valid}, 32'h0);
            end
        end
    end

    initial begin
        mreq_t idle, rd0, rd1, wr1;
        idle = '0;
        rd0  = mk(1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
        rd1  = mk(1'b1, 32'h20, 1'b0, 4'h0, 32'h0);
        wr1  = mk(1'b1, 32'h40, 1'b1, 4'b0011, 32'hA5A5_A5A5);

        areset = 1'b1;
        {m0_request, m0_address, m0_write_enable, m0_write_byte_enable, m0_write_data} = '0;
        {m1_request, m1_address, m1_write_enable, m1_write_byte_enable, m1_write_data} = '0;
        ram_grant = 1'b0;

        // Reset holds grants and the RAM request low even with requests and ram_grant present.
        step(rd0, rd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_ram_request", {31'h0, ram_request}, 32'h0);
        check("reset_valids", {30'h0, m1_valid, m0_valid}, 32'h0);
        step(idle, idle, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef TCM_ARB_FIXED_PRIO_EN
        repeat (5) step(rd0, rd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
`else
        step(rd0, rd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(rd0, rd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(rd0, rd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(rd0, rd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
`endif
        step(idle, idle, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Lone m1 write: RAM port mirrors m1, response routes back to m1.
        step(idle, wr1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("wr_ram_request", {31'h0, ram_request}, 32'h1);
        check("wr_ram_address", ram_address, 32'h40);
        check("wr_ram_we", {31'h0, ram_write_enable}, 32'h1);
        check("wr_ram_be", {28'h0, ram_write_byte_enable}, 32'h3);
        check("wr_ram_data", ram_write_data, 32'hA5A5_A5A5);
        step(idle, idle, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifndef TCM_ARB_FIXED_PRIO_EN
        // Lone m0 grant leaves prio at m1; a 3-cycle stall must not move it.
        step(rd0, idle, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(rd0, rd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check("stall_select_m1", ram_address, 32'h20);
        end
        step(rd0, rd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(idle, idle, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        // Grant to m0 (prio moves to m1), then reset: no response, and prio returns to RESET_PRIO.
        step(rd0, rd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(rd0, rd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_drop_valids", {30'h0, m1_valid, m0_valid}, 32'h0);
        check("rst_ram_request", {31'h0, ram_request}, 32'h0);
        step(rd0, rd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(idle, idle, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Stray ram_valid with nothing outstanding is dropped.
        step(idle, idle, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("stray_valids", {30'h0, m1_valid, m0_valid}, 32'h0);
        check("stray_m0_data", m0_read_data, 32'h0);
        check("stray_m1_data", m1_read_data, 32'h0);
        step(idle, idle, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(idle, idle, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
